// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: one 128-bit state in, COLS_PER_CYCLE
// columns transformed per clock, result held on a valid/ready output port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for a state to load
// BUSY  | transforming one column group per cycle, in ascending order
// DONE  | out_valid high, result held until out_ready
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $fatal(1, "inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [1:0]   col_cnt, col_cnt_next;
    logic [127:0] work, work_next;
    logic [1:0]   idx;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Column word is {row0, row1, row2, row3}, row 0 in the top byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        r1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        r2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        r3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        return {r0, r1, r2, r3};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            col_cnt <= 2'd0;
            work    <= 128'h0;
        end else begin
            state   <= state_next;
            col_cnt <= col_cnt_next;
            work    <= work_next;
        end
    end

    always_comb begin
        state_next   = state;
        col_cnt_next = col_cnt;
        work_next    = work;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        idx          = 2'd0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_next    = in_state;
                    col_cnt_next = 2'd0;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                // Column c lives at bits [(3-c)*32 +: 32]; for a 2-bit c, 3-c is ~c.
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    idx = col_cnt + 2'(g);
                    work_next[{~idx, 5'b00000} +: 32] = inv_mix_col(work[{~idx, 5'b00000} +: 32]);
                end
                col_cnt_next = col_cnt + STEP;
                if (col_cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_state = work;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: one instance per COLS_PER_CYCLE (1, 2, 4),
// checked against a matrix-form GF(2^8) model of (Inv)MixColumns.
module tb_inv_mix_columns_seq;

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_9fdc589d;
    localparam logic [127:0] E2 = 128'h2d26314c_d4d4d4d5_db135345_f20a225c;
    localparam logic [127:0] V3 = {4{32'h01010101}};
    localparam logic [31:0]  INV_ROW = 32'h0e0b0d09;
    localparam logic [31:0]  FWD_ROW = 32'h02030101;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_valid [3];
    logic [127:0] in_state [3];
    logic         in_ready [3];
    logic         out_valid [3];
    logic [127:0] out_state [3];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rand_bp = 1'b0;
    logic [127:0] exp_q [3][$];
    int acc_cyc [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_state  (in_state[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready),
                .out_state (out_state[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain shift-and-add GF(2^8) product, polynomial 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product on every column; row is the first matrix row.
    function automatic logic [127:0] xform(input logic [127:0] s, input logic [31:0] row);
        logic [127:0] res;
        logic [7:0] accb;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                accb = 8'h00;
                for (int k = 0; k < 4; k++)
                    accb = accb ^ gmul(row[31 - 8 * ((k - r + 4) % 4) -: 8], s[127 - 8 * (4 * c + k) -: 8]);
                res[127 - 8 * (4 * c + r) -: 8] = accb;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        return xform(s, INV_ROW);
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        return xform(s, FWD_ROW);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input int i, input logic [127:0] s, output int acc);
        int b;
        b = 0;
        acc = -1;
        while (!in_ready[i] && b < 60) begin
            tick();
            b++;
        end
        if (!in_ready[i]) begin
            chk("send_timeout", 128'(i), 128'(-1));
            return;
        end
        in_valid[i] = 1'b1;
        in_state[i] = s;
        tick();
        acc = cyc;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_out(input int i, output logic [127:0] v);
        int b;
        b = 0;
        while (!out_valid[i] && b < 60) begin
            tick();
            b++;
        end
        if (!out_valid[i]) chk("out_timeout", 128'(i), 128'(-1));
        v = out_state[i];
    endtask

    task automatic monitor();
        logic         prev_v [3];
        logic [127:0] prev_s [3];
        logic         prev_r;
        prev_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            prev_v[i] = 1'b0;
            prev_s[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) begin
                    exp_q[i].delete();
                    prev_v[i] = 1'b0;
                end
                continue;
            end
            for (int i = 0; i < 3; i++) begin
                chk("no_x", 128'($isunknown(out_state[i])), 128'(0));
                if (prev_v[i] && !prev_r) begin
                    chk("hold_valid", 128'(out_valid[i]), 128'(1));
                    chk("hold_state", out_state[i], prev_s[i]);
                end
                if (out_valid[i] === 1'b1 && !prev_v[i])
                    chk("latency", 128'(cyc - acc_cyc[i]), 128'((4 >> i) + 1));
                if (in_valid[i] && in_ready[i]) begin
                    exp_q[i].push_back(ref_inv(in_state[i]));
                    acc_cyc[i] = cyc;
                end
                if (out_valid[i] && out_ready) begin
                    if (exp_q[i].size() == 0) chk("spurious_out", out_state[i], 128'hx);
                    else chk("result", out_state[i], exp_q[i].pop_front());
                end
                prev_v[i] = out_valid[i];
                prev_s[i] = out_state[i];
            end
            prev_r = out_ready;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev_acc, n;
        logic [127:0] v, s;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            in_state[i] = '0;
            acc_cyc[i] = 0;
        end
        fork
            monitor();
        join_none

        chk("model_inv_v1", ref_inv(V1), E1);
        chk("model_inv_v2", ref_inv(V2), E2);
        chk("model_mix_e2", ref_mix(E2), V2);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 128'(in_ready[i]), 128'(1));
            chk("rst_out_valid", 128'(out_valid[i]), 128'(0));
            chk("rst_out_state", out_state[i], 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            n = 4 >> i;
            out_ready = 1'b1;

            send(i, V1, acc);
            wait_out(i, v);
            chk("single_col", v, E1);
            tick();

            send(i, V2, acc);
            wait_out(i, v);
            chk("round_trip", v, E2);
            tick();

            out_ready = 1'b0;
            send(i, V2, acc);
            wait_out(i, v);
            chk("bp_value", v, E2);
            repeat (7) begin
                tick();
                chk("bp_valid", 128'(out_valid[i]), 128'(1));
                chk("bp_state", out_state[i], v);
                chk("bp_in_ready", 128'(in_ready[i]), 128'(0));
            end
            out_ready = 1'b1;
            tick();
            chk("bp_release_ready", 128'(in_ready[i]), 128'(1));
            chk("bp_release_valid", 128'(out_valid[i]), 128'(0));

            send(i, V1, acc);
            in_valid[i] = 1'b1;
            in_state[i] = V2;
            tick();
            in_valid[i] = 1'b0;
            wait_out(i, v);
            chk("busy_ignore", v, E1);
            tick();
            repeat (10) begin
                tick();
                chk("busy_no_second", 128'(out_valid[i]), 128'(0));
            end

            send(i, V1, prev_acc);
            for (int t = 0; t < 3; t++) begin
                send(i, $urandom() % 2 == 0 ? V1 : V2, acc);
                chk("throughput", 128'(acc - prev_acc), 128'(n + 2));
                prev_acc = acc;
            end
            repeat (n + 3) tick();

            if (i == 0) begin
                send(i, V2, acc);
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk("midrst_in_ready", 128'(in_ready[i]), 128'(1));
                chk("midrst_out_valid", 128'(out_valid[i]), 128'(0));
                chk("midrst_out_state", out_state[i], 128'h0);
                repeat (2) @(posedge clk);
                #3;
                rst_n = 1'b1;
                repeat (10) begin
                    tick();
                    chk("midrst_no_out", 128'(out_valid[i]), 128'(0));
                end
                send(i, V3, acc);
                wait_out(i, v);
                chk("midrst_new", v, V3);
                tick();
            end

            rand_bp = 1'b1;
            repeat (400) begin
                s = {$urandom(), $urandom(), $urandom(), $urandom()};
                send(i, ref_mix(s), acc);
            end
            rand_bp = 1'b0;
            out_ready = 1'b1;
            repeat (12) tick();
            chk("drain", 128'(exp_q[i].size()), 128'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
